// File: rtl/shifter_pipe_pkg.sv
// Shared types for the two-stage ARM-style barrel shifter pipeline.
package shifter_pkg;

  // Request modes; the reserved encoding decodes exactly like SHIFT_IMM.
  typedef enum logic [1:0] {
    MODE_IMM_ROT   = 2'b00,
    MODE_SHIFT_IMM = 2'b01,
    MODE_SHIFT_REG = 2'b10,
    MODE_RSVD      = 2'b11
  } mode_e;

  // Shift kinds as encoded in src2[6:5].
  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } sh_e;

  // Decoded operation held in stage 1. pass forces out=data, C=carry_in;
  // rrx selects rotate-right-extended; amt is the effective shift amount.
  typedef struct packed {
    sh_e        sh;
    logic [7:0] amt;
    logic       pass;
    logic       rrx;
  } shift_op_t;

endpackage

// File: rtl/shifter_pipe_if.sv
// Request/response bus of the shifter pipeline.
interface shifter_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       mode;
  logic [WIDTH-1:0] data;
  logic [11:0]      src2;
  logic [7:0]       rs_amt;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             carry_out;

  // Requester / result consumer side.
  modport master (
    output in_valid, mode, data, src2, rs_amt, carry_in, out_ready,
    input  in_ready, out_valid, out, carry_out
  );

  // Shifter side.
  modport slave (
    input  in_valid, mode, data, src2, rs_amt, carry_in, out_ready,
    output in_ready, out_valid, out, carry_out
  );
endinterface

// File: rtl/shifter_pipe_shift_core.sv
// Combinational barrel shifter with ARM carry semantics, fed by a decoded op.
module shift_core
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_data,
  input  shift_op_t        i_op,
  input  logic             i_carry,
  output logic [WIDTH-1:0] o_out,
  output logic             o_carry
);
  localparam int         LW = $clog2(WIDTH);
  localparam logic [7:0] W8 = 8'(WIDTH);

  // Low amount bits: exact amount when below WIDTH, amount mod WIDTH for ROR.
  logic [LW-1:0]           w_sa;
  logic [LW:0]             w_rsa;
  logic [WIDTH:0]          w_lsl;
  logic [WIDTH:0]          w_lsr;
  logic signed [WIDTH:0]   w_asr;
  logic [WIDTH-1:0]        w_ror;

  assign w_sa  = i_op.amt[LW-1:0];
  assign w_rsa = (LW+1)'(WIDTH) - {1'b0, w_sa};
  // The extra bit on each side captures the last bit shifted out (carry).
  assign w_lsl = {1'b0, i_data} << w_sa;
  assign w_lsr = {i_data, 1'b0} >> w_sa;
  assign w_asr = $signed({i_data, 1'b0}) >>> w_sa;
  assign w_ror = (i_data >> w_sa) | (i_data << w_rsa);

  // Select result and carry, covering the out-of-range and zero-amount cases.
  always_comb begin
    o_out   = i_data;
    o_carry = i_carry;
    if (i_op.pass) begin
      o_out   = i_data;
      o_carry = i_carry;
    end else if (i_op.rrx) begin
      o_out   = {i_carry, i_data[WIDTH-1:1]};
      o_carry = i_data[0];
    end else begin
      case (i_op.sh)
        SH_LSL: begin
          if (i_op.amt < W8) begin
            o_out   = w_lsl[WIDTH-1:0];
            o_carry = w_lsl[WIDTH];
          end else begin
            o_out   = '0;
            o_carry = (i_op.amt == W8) ? i_data[0] : 1'b0;
          end
        end
        SH_LSR: begin
          if (i_op.amt < W8) begin
            o_out   = w_lsr[WIDTH:1];
            o_carry = w_lsr[0];
          end else begin
            o_out   = '0;
            o_carry = (i_op.amt == W8) ? i_data[WIDTH-1] : 1'b0;
          end
        end
        SH_ASR: begin
          if (i_op.amt < W8) begin
            o_out   = w_asr[WIDTH:1];
            o_carry = w_asr[0];
          end else begin
            o_out   = {WIDTH{i_data[WIDTH-1]}};
            o_carry = i_data[WIDTH-1];
          end
        end
        SH_ROR: begin
          o_out   = (w_sa == '0) ? i_data : w_ror;
          o_carry = (w_sa == '0) ? i_data[WIDTH-1] : w_ror[WIDTH-1];
        end
        default: begin
          o_out   = i_data;
          o_carry = i_carry;
        end
      endcase
    end
  end
endmodule

// File: rtl/shifter_pipe.sv
// Two-stage shifter pipeline: S1 holds the decoded op, S2 holds the result.
module shifter_pipe
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  shifter_pipe_if.slave  bus
);
  logic             r_s1_vld;
  shift_op_t        r_s1_op;
  logic [WIDTH-1:0] r_s1_data;
  logic             r_s1_cin;
  logic             r_s2_vld;
  logic [WIDTH-1:0] r_s2_out;
  logic             r_s2_c;

  shift_op_t        w_op;
  logic [WIDTH-1:0] w_operand;
  logic [WIDTH-1:0] w_res;
  logic             w_res_c;
  logic             w_s2_adv;
  logic             w_in_ready;

  // A stage may take new contents when it is empty or being drained.
  assign w_s2_adv   = !r_s2_vld || bus.out_ready;
  assign w_in_ready = !r_s1_vld || w_s2_adv;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_s2_vld;
  assign bus.out       = r_s2_out;
  assign bus.carry_out = r_s2_c;

  // Decode mode/src2/rs_amt into a uniform shift op and operand.
  always_comb begin
    w_op.sh   = sh_e'(bus.src2[6:5]);
    w_op.amt  = {3'b000, bus.src2[11:7]};
    w_op.pass = 1'b0;
    w_op.rrx  = 1'b0;
    w_operand = bus.data;
    case (mode_e'(bus.mode))
      MODE_IMM_ROT: begin
        w_op.sh   = SH_ROR;
        w_op.amt  = {3'b000, bus.src2[11:8], 1'b0};
        w_op.pass = (bus.src2[11:8] == 4'd0);
        w_operand = {{(WIDTH-8){1'b0}}, bus.src2[7:0]};
      end
      MODE_SHIFT_REG: begin
        w_op.amt  = bus.rs_amt;
        w_op.pass = (bus.rs_amt == 8'd0);
      end
      default: begin
        // Immediate amount 0 encodes the special forms.
        if (bus.src2[11:7] == 5'd0) begin
          case (sh_e'(bus.src2[6:5]))
            SH_LSL:  w_op.pass = 1'b1;
            SH_ROR:  w_op.rrx  = 1'b1;
            default: w_op.amt  = 8'(WIDTH);
          endcase
        end
      end
    endcase
  end

  // Stage valids: cleared asynchronously so in-flight work is discarded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
    end else begin
      if (w_in_ready) r_s1_vld <= bus.in_valid;
      if (w_s2_adv)   r_s2_vld <= r_s1_vld;
    end
  end

  // ---- S1: decoded op, operand and carry_in ----
  always_ff @(posedge clk) begin
    if (w_in_ready && bus.in_valid) begin
      r_s1_op   <= w_op;
      r_s1_data <= w_operand;
      r_s1_cin  <= bus.carry_in;
    end
  end

  shift_core #(.WIDTH(WIDTH)) u_core (
    .i_data  (r_s1_data),
    .i_op    (r_s1_op),
    .i_carry (r_s1_cin),
    .o_out   (w_res),
    .o_carry (w_res_c)
  );

  // ---- S2: registered result, zero in reset, held while stalled ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s2_out <= '0;
      r_s2_c   <= 1'b0;
    end else if (w_s2_adv && r_s1_vld) begin
      r_s2_out <= w_res;
      r_s2_c   <= w_res_c;
    end
  end
endmodule

// File: tb/tb_shifter_pipe.sv
// Scoreboard bench for shifter_pipe: directed vectors, decoupled monitor.
module tb_shifter_pipe;
  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   ready_mode = 0;   // 0: always ready, 1: toggle 1010..., 2: never ready
  bit   tog = 1'b0;

  typedef struct {
    logic [31:0] o;
    logic        c;
    int          acc;
    bit          lat;
  } exp_t;
  exp_t q[$];

  shifter_pipe_if #(.WIDTH(32)) bus();

  shifter_pipe #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // Monitor: drives out_ready, compares the presented result against the
  // oldest expectation, and checks in_ready against the occupancy model.
  initial begin
    logic exp_rdy;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       begin tog = !tog; bus.out_ready = tog; end
        default: bus.out_ready = 1'b0;
      endcase
      #1;
      exp_rdy = !(q.size() == 2 && !bus.out_ready);
      checks++;
      if (bus.in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL in_ready got=%b want=%b (t=%0t)", bus.in_ready, exp_rdy, $time);
      end
      if (bus.out_valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out_valid got=1 want=0 out=%h (t=%0t)", bus.out, $time);
        end else begin
          if (bus.out !== q[0].o || bus.carry_out !== q[0].c) begin
            errors++;
            $display("FAIL result got out=%h c=%b want out=%h c=%b (t=%0t)",
                     bus.out, bus.carry_out, q[0].o, q[0].c, $time);
          end
          if (q[0].lat) begin
            checks++;
            if (cyc - q[0].acc != 2) begin
              errors++;
              $display("FAIL latency got=%0d want=2", cyc - q[0].acc);
            end
            q[0].lat = 1'b0;
          end
          if (bus.out_ready) void'(q.pop_front());
        end
      end
    end
  end

  // Present one request until accepted; queue its hand-computed result.
  task automatic send(input logic [1:0] m, input logic [31:0] d, input logic [11:0] s2,
                      input logic [7:0] rs, input logic ci,
                      input logic [31:0] eo, input logic ec);
    int  waited = 0;
    bit  done = 1'b0;
    int  acc;
    @(negedge clk);
    bus.mode = m; bus.data = d; bus.src2 = s2; bus.rs_amt = rs; bus.carry_in = ci;
    bus.in_valid = 1'b1;
    while (!done) begin
      #1;
      if (bus.in_ready) begin
        acc = cyc;
        @(posedge clk);
        q.push_back('{o: eo, c: ec, acc: acc, lat: (ready_mode == 0)});
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 50) begin
          checks++; errors++;
          $display("FAIL accept_timeout got=no_accept want=accept");
          done = 1'b1;
        end else begin
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic idle_drain();
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending want=0", q.size());
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.in_valid = 1'b0; bus.mode = 2'b00; bus.data = '0; bus.src2 = '0;
    bus.rs_amt = '0; bus.carry_in = 1'b0; bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out !== 32'h0 || bus.carry_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got v=%b out=%h c=%b want v=0 out=0 c=0",
               bus.out_valid, bus.out, bus.carry_out);
    end
    @(negedge clk);
    reset = 1'b1;
    #2;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL in_ready_after_reset got=%b want=1", bus.in_ready);
    end

    // Phase 1: always ready, back-to-back, latency checked.
    ready_mode = 0;
    send(2'b00, 32'h0,        12'h4FF, 8'd0, 1'b0, 32'hFF000000, 1'b1);
    send(2'b00, 32'h0,        12'h05A, 8'd0, 1'b1, 32'h0000005A, 1'b1);
    send(2'b00, 32'h0,        12'h101, 8'd0, 1'b0, 32'h40000000, 1'b0);
    send(2'b01, 32'h00000003, 12'h060, 8'd0, 1'b1, 32'h80000001, 1'b1);
    send(2'b01, 32'hF0000001, 12'h200, 8'd0, 1'b0, 32'h00000010, 1'b1);
    send(2'b01, 32'h12345678, 12'h000, 8'd0, 1'b1, 32'h12345678, 1'b1);
    send(2'b01, 32'h80000000, 12'h020, 8'd0, 1'b0, 32'h00000000, 1'b1);
    send(2'b01, 32'h80000001, 12'h040, 8'd0, 1'b0, 32'hFFFFFFFF, 1'b1);
    send(2'b01, 32'h8000000F, 12'h240, 8'd0, 1'b0, 32'hF8000000, 1'b1);
    send(2'b01, 32'h00000003, 12'h0A0, 8'd0, 1'b0, 32'h00000001, 1'b1);
    send(2'b11, 32'h00000001, 12'h200, 8'd0, 1'b0, 32'h00000010, 1'b0);
    idle_drain();

    // Phase 2: out_ready toggling, register-specified amounts.
    ready_mode = 1;
    send(2'b10, 32'h00000001, 12'h000, 8'd32,  1'b0, 32'h00000000, 1'b1);
    send(2'b10, 32'h00000001, 12'h000, 8'd33,  1'b1, 32'h00000000, 1'b0);
    send(2'b10, 32'h80000000, 12'h040, 8'd200, 1'b0, 32'hFFFFFFFF, 1'b1);
    send(2'b10, 32'h80000000, 12'h040, 8'd0,   1'b1, 32'h80000000, 1'b1);
    send(2'b10, 32'h80000000, 12'h020, 8'd32,  1'b0, 32'h00000000, 1'b1);
    send(2'b10, 32'hFFFFFFFF, 12'h020, 8'd40,  1'b1, 32'h00000000, 1'b0);
    send(2'b10, 32'h80000001, 12'h060, 8'd64,  1'b0, 32'h80000001, 1'b1);
    send(2'b10, 32'h0000001F, 12'h060, 8'd36,  1'b0, 32'hF0000001, 1'b1);
    send(2'b10, 32'h00000003, 12'h000, 8'd31,  1'b0, 32'h80000000, 1'b1);
    send(2'b10, 32'h0000ABCD, 12'h060, 8'd0,   1'b0, 32'h0000ABCD, 1'b0);
    send(2'b10, 32'h00000180, 12'h020, 8'd8,   1'b0, 32'h00000001, 1'b1);
    idle_drain();

    // Phase 3: reset with two requests in flight.
    ready_mode = 2;
    send(2'b10, 32'h00000001, 12'h000, 8'd1, 1'b0, 32'h00000002, 1'b0);
    send(2'b10, 32'h00000001, 12'h000, 8'd2, 1'b0, 32'h00000004, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b0;
    q.delete();
    #2;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out !== 32'h0 || bus.carry_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_midflight got v=%b out=%h c=%b want v=0 out=0 c=0",
               bus.out_valid, bus.out, bus.carry_out);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ready_mode = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #2;
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL stale_after_reset got=%b want=0", bus.out_valid);
      end
    end
    send(2'b01, 32'h00000001, 12'h380, 8'd0, 1'b0, 32'h00000080, 1'b0);
    idle_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
